// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state, size codes and IO tag for the unified RAM port controller
//
// Purpose: types and constants used by mem_ctrl and its bench.
//   mc_state_e   controller FSM states
//   SZ_B/H/W     LSB access size codes
//   IO_TAG_DEF   addr[17:16] value of the memory-mapped IO region
//   size_to_len  byte count of an LSB access (unknown codes treated as word)
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    MC_IDLE  = 3'd0,
    MC_IF_RD = 3'd1,
    MC_LS_RD = 3'd2,
    MC_LS_WR = 3'd3,
    MC_DONE  = 3'd4
  } mc_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] IO_TAG_DEF = 2'b11;
  localparam logic [2:0] FETCH_LEN  = 3'd4;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM port arbiter/sequencer for instruction fetch and load/store
//
// Purpose: grants the single byte-wide RAM port to the load/store unit (priority)
// or the instruction fetcher, walks the access one byte per cycle, assembles read
// data little-endian and returns a one-cycle done pulse to the winner.
// Ports:
//   clk, rst (sync, active low), rdy (global enable), clear (flush), io_buffer_full
//   IF_req/IF_addr    -> IF_flag/IF_inst       word fetch
//   LSB_req/LSB_wr/LSB_size/LSB_addr/LSB_wdata -> LSB_flag/LSB_rdata
//   mem_din (read byte, 1-cycle latency), mem_dout/mem_a/mem_wr to RAM
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_TAG = IO_TAG_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic        IF_req,
  input  logic [31:0] IF_addr,
  output logic        IF_flag,
  output logic [31:0] IF_inst,
  input  logic        LSB_req,
  input  logic        LSB_wr,
  input  logic [1:0]  LSB_size,
  input  logic [31:0] LSB_addr,
  input  logic [31:0] LSB_wdata,
  output logic        LSB_flag,
  output logic [31:0] LSB_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  mc_state_e   state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  len_q;
  logic [23:0] wdata_q;     // store bytes still to be issued, next one in [7:0]
  logic        io_q;        // access targets the IO region
  logic [31:0] asm_q;
  logic [31:0] asm_d;
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;
  logic        if_flag_q;
  logic        lsb_flag_q;
  logic [31:0] if_inst_q;
  logic [31:0] lsb_rdata_q;

  logic [1:0]  cap_idx;
  logic        grant_io;

  // In read states cnt counts cycles since grant; the byte arriving now on
  // mem_din belongs to the address issued one cycle earlier, i.e. index cnt-1.
  assign cap_idx  = cnt_q[1:0] - 2'd1;
  assign grant_io = (LSB_addr[17:16] == IO_TAG);

  always_comb begin
    asm_d = asm_q;
    asm_d[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= MC_IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      wdata_q     <= 24'd0;
      io_q        <= 1'b0;
      asm_q       <= 32'd0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      if_flag_q   <= 1'b0;
      lsb_flag_q  <= 1'b0;
      if_inst_q   <= 32'd0;
      lsb_rdata_q <= 32'd0;
    end else if (rdy) begin
      case (state_q)
        MC_IDLE: begin
          // LSB first; under a flush only a committed store may start.
          if (LSB_req && (LSB_wr || !clear)) begin
            mem_a_q <= LSB_addr;
            cnt_q   <= 3'd0;
            len_q   <= size_to_len(LSB_size);
            asm_q   <= 32'd0;
            io_q    <= grant_io;
            if (LSB_wr) begin
              state_q    <= MC_LS_WR;
              mem_dout_q <= LSB_wdata[7:0];
              wdata_q    <= LSB_wdata[31:8];
              mem_wr_q   <= !(grant_io && io_buffer_full);
            end else begin
              state_q <= MC_LS_RD;
            end
          end else if (IF_req && !clear) begin
            state_q <= MC_IF_RD;
            mem_a_q <= IF_addr;
            cnt_q   <= 3'd0;
            len_q   <= FETCH_LEN;
            asm_q   <= 32'd0;
            io_q    <= 1'b0;
          end
        end

        MC_IF_RD, MC_LS_RD: begin
          if (clear) begin
            state_q <= MC_IDLE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q != 3'd0) asm_q <= asm_d;
            if ((cnt_q + 3'd1) < len_q) mem_a_q <= mem_a_q + 32'd1;
            if (cnt_q == len_q) begin
              state_q <= MC_DONE;
              if (state_q == MC_IF_RD) begin
                if_flag_q <= 1'b1;
                if_inst_q <= asm_d;
              end else begin
                lsb_flag_q  <= 1'b1;
                lsb_rdata_q <= asm_d;
              end
            end
          end
        end

        MC_LS_WR: begin
          // cnt is the index of the byte on mem_dout; it only advances once
          // that byte has actually gone out with mem_wr high.
          if (mem_wr_q) begin
            if (cnt_q == len_q - 3'd1) begin
              mem_wr_q   <= 1'b0;
              lsb_flag_q <= 1'b1;
              state_q    <= MC_DONE;
            end else begin
              cnt_q      <= cnt_q + 3'd1;
              mem_a_q    <= mem_a_q + 32'd1;
              mem_dout_q <= wdata_q[7:0];
              wdata_q    <= {8'h00, wdata_q[23:8]};
              mem_wr_q   <= !(io_q && io_buffer_full);
            end
          end else begin
            mem_wr_q <= !(io_q && io_buffer_full);
          end
        end

        MC_DONE: begin
          if_flag_q  <= 1'b0;
          lsb_flag_q <= 1'b0;
          state_q    <= MC_IDLE;
        end

        default: state_q <= MC_IDLE;
      endcase
    end
  end

  assign IF_flag   = if_flag_q;
  assign IF_inst   = if_inst_q;
  assign LSB_flag  = lsb_flag_q;
  assign LSB_rdata = lsb_rdata_q;
  assign mem_dout  = mem_dout_q;
  assign mem_a     = mem_a_q;
  // Masking with rdy keeps a frozen write cycle from being seen twice by RAM.
  assign mem_wr    = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, clear, io_buffer_full;
  logic        IF_req;
  logic [31:0] IF_addr;
  logic        IF_flag;
  logic [31:0] IF_inst;
  logic        LSB_req, LSB_wr;
  logic [1:0]  LSB_size;
  logic [31:0] LSB_addr, LSB_wdata;
  logic        LSB_flag;
  logic [31:0] LSB_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .io_buffer_full(io_buffer_full),
    .IF_req(IF_req), .IF_addr(IF_addr), .IF_flag(IF_flag), .IF_inst(IF_inst),
    .LSB_req(LSB_req), .LSB_wr(LSB_wr), .LSB_size(LSB_size), .LSB_addr(LSB_addr),
    .LSB_wdata(LSB_wdata), .LSB_flag(LSB_flag), .LSB_rdata(LSB_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // RAM model: 8 KiB, 1-cycle read latency, preloaded while rst is low.
  logic [7:0] ram [0:8191];
  int         wr_cnt;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[12:0]];
    if (!rst) begin
      for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
      ram[13'h100] = 8'h13; ram[13'h101] = 8'h05; ram[13'h102] = 8'h00; ram[13'h103] = 8'h00;
      ram[13'h200] = 8'h11; ram[13'h201] = 8'h22; ram[13'h202] = 8'hEF; ram[13'h203] = 8'hBE;
      ram[13'h204] = 8'h44; ram[13'h205] = 8'h55; ram[13'h206] = 8'h66; ram[13'h207] = 8'h77;
      wr_cnt <= 0;
    end else if (mem_wr) begin
      ram[mem_a[12:0]] = mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ram_word(input int a);
    return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
  endfunction

  task automatic wait_lsb(input int limit, output bit seen);
    seen = 0;
    for (int c = 0; c < limit && !seen; c++) begin
      tick();
      if (LSB_flag) seen = 1;
    end
  endtask

  typedef struct {
    logic        is_lsb;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    bit seen;
    seen = 0;
    if (v.is_lsb) begin
      LSB_req = 1; LSB_wr = v.wr; LSB_size = v.size; LSB_addr = v.addr; LSB_wdata = v.wdata;
    end else begin
      IF_req = 1; IF_addr = v.addr;
    end
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (v.is_lsb ? LSB_flag : IF_flag) seen = 1;
    end
    check($sformatf("vec%0d_done", idx), {31'd0, seen}, 32'd1);
    if (seen) begin
      check($sformatf("vec%0d_other_flag", idx), {31'd0, (v.is_lsb ? IF_flag : LSB_flag)}, 32'd0);
      if (!v.wr) check($sformatf("vec%0d_data", idx), v.is_lsb ? LSB_rdata : IF_inst, v.exp_data);
    end
    LSB_req = 0; LSB_wr = 0; IF_req = 0;
    tick();
    check($sformatf("vec%0d_pulse", idx), {30'd0, IF_flag, LSB_flag}, 32'd0);
  endtask

  vec_t vecs [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    bit          bad;
    int          base;
    logic [31:0] w;

    vecs[0]  = '{1'b0, 1'b0, SZ_W, 32'h0000_0100, 32'h0,         32'h0000_0513};
    vecs[1]  = '{1'b1, 1'b0, SZ_B, 32'h0000_0203, 32'h0,         32'h0000_00BE};
    vecs[2]  = '{1'b1, 1'b0, SZ_H, 32'h0000_0202, 32'h0,         32'h0000_BEEF};
    vecs[3]  = '{1'b1, 1'b0, SZ_W, 32'h0000_0204, 32'h0,         32'h7766_5544};
    vecs[4]  = '{1'b1, 1'b0, SZ_W, 32'h0000_0201, 32'h0,         32'h44BE_EF22};
    vecs[5]  = '{1'b1, 1'b1, SZ_H, 32'h0000_0300, 32'h1234_CAFE, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, SZ_W, 32'h0000_0300, 32'h0,         32'h0000_CAFE};
    vecs[7]  = '{1'b1, 1'b1, SZ_B, 32'h0000_0302, 32'hFFFF_FF5A, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, SZ_W, 32'h0000_0300, 32'h0,         32'h005A_CAFE};
    vecs[9]  = '{1'b0, 1'b0, SZ_W, 32'h0000_0204, 32'h0,         32'h7766_5544};
    vecs[10] = '{1'b1, 1'b0, SZ_H, 32'h0000_0206, 32'h0,         32'h0000_7766};
    vecs[11] = '{1'b1, 1'b0, SZ_B, 32'h0000_0200, 32'h0,         32'h0000_0011};

    rst = 0; rdy = 1; clear = 0; io_buffer_full = 0;
    IF_req = 0; IF_addr = 0;
    LSB_req = 0; LSB_wr = 0; LSB_size = 0; LSB_addr = 0; LSB_wdata = 0;

    // Reset for two cycles, then a fetch granted right after release.
    tick(); tick();
    check("rst_flags", {29'd0, IF_flag, LSB_flag, mem_wr}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_if_inst", IF_inst, 32'd0);
    check("rst_lsb_rdata", LSB_rdata, 32'd0);

    rst = 1; IF_req = 1; IF_addr = 32'h100;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("fetch_addr_c%0d", c), mem_a, 32'h100 + c);
      check($sformatf("fetch_noflag_c%0d", c), {31'd0, IF_flag}, 32'd0);
    end
    tick();
    check("fetch_noflag_c4", {31'd0, IF_flag}, 32'd0);
    tick();
    check("fetch_flag_c5", {31'd0, IF_flag}, 32'd1);
    check("fetch_inst", IF_inst, 32'h0000_0513);
    IF_req = 0;
    tick();
    check("fetch_dead_cycle", {31'd0, IF_flag}, 32'd0);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // LSB wins against a simultaneous fetch; fetch begins 2 cycles after LSB_flag.
    IF_req = 1; IF_addr = 32'h100;
    LSB_req = 1; LSB_wr = 0; LSB_size = SZ_H; LSB_addr = 32'h202;
    bad = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (IF_flag) bad = 1;
      if (LSB_flag) seen = 1;
    end
    check("arb_lsb_done", {31'd0, seen}, 32'd1);
    check("arb_no_if_first", {31'd0, bad}, 32'd0);
    check("arb_lsb_rdata", LSB_rdata, 32'h0000_BEEF);
    LSB_req = 0;
    tick();
    check("arb_idle_mem_a", mem_a, 32'h203);
    tick();
    check("arb_fetch_start", mem_a, 32'h100);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (IF_flag) seen = 1;
    end
    check("arb_if_done", {31'd0, seen}, 32'd1);
    check("arb_if_inst", IF_inst, 32'h0000_0513);
    IF_req = 0;
    tick();

    // Word store: four write cycles, then the flag.
    LSB_req = 1; LSB_wr = 1; LSB_size = SZ_W; LSB_addr = 32'h1000; LSB_wdata = 32'hDEAD_BEEF;
    w = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("st_wr_c%0d", k), {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, w[7:0]});
      check($sformatf("st_addr_c%0d", k), mem_a, 32'h1000 + k);
      w = w >> 8;
    end
    tick();
    check("st_flag", {30'd0, LSB_flag, mem_wr}, 32'd2);
    LSB_req = 0; LSB_wr = 0;
    tick();
    check("st_ram", ram_word(32'h1000), 32'hDEAD_BEEF);

    // Flush during a fetch at c2: aborted, IDLE next cycle, store still granted under clear.
    IF_req = 1; IF_addr = 32'h200;
    tick(); tick(); tick();
    clear = 1; IF_req = 0;
    tick();
    check("clr_rd_noflag", {31'd0, IF_flag}, 32'd0);
    check("clr_rd_mem_a_held", mem_a, 32'h202);
    LSB_req = 1; LSB_wr = 1; LSB_size = SZ_B; LSB_addr = 32'h400; LSB_wdata = 32'h0000_0077;
    tick();
    check("clr_store_granted", {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, 8'h77});
    check("clr_store_addr", mem_a, 32'h400);
    tick();
    check("clr_store_flag", {30'd0, IF_flag, LSB_flag}, 32'd1);
    LSB_req = 0; LSB_wr = 0;
    tick();
    LSB_req = 1; LSB_wr = 0; LSB_size = SZ_B; LSB_addr = 32'h200;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (LSB_flag || mem_a == 32'h200) bad = 1;
    end
    check("clr_load_blocked", {31'd0, bad}, 32'd0);
    clear = 0;
    wait_lsb(20, seen);
    check("clr_load_after", {31'd0, seen}, 32'd1);
    check("clr_load_data", LSB_rdata, 32'h0000_0011);
    LSB_req = 0;
    tick();

    // Flush during a store: all four bytes still go out.
    base = wr_cnt;
    LSB_req = 1; LSB_wr = 1; LSB_size = SZ_W; LSB_addr = 32'h500; LSB_wdata = 32'h0403_0201;
    tick(); tick();
    clear = 1;
    wait_lsb(20, seen);
    check("clr_wr_flag", {31'd0, seen}, 32'd1);
    LSB_req = 0; LSB_wr = 0; clear = 0;
    tick();
    check("clr_wr_count", wr_cnt - base, 32'd4);
    check("clr_wr_ram", ram_word(32'h500), 32'h0403_0201);

    // IO region store held off while the IO buffer is full.
    io_buffer_full = 1;
    LSB_req = 1; LSB_wr = 1; LSB_size = SZ_B; LSB_addr = 32'h0003_0000; LSB_wdata = 32'h0000_00A5;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (mem_wr || LSB_flag) bad = 1;
    end
    check("io_stalled", {31'd0, bad}, 32'd0);
    io_buffer_full = 0;
    tick();
    check("io_issue", {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, 8'hA5});
    check("io_issue_addr", mem_a, 32'h0003_0000);
    tick();
    check("io_flag", {30'd0, LSB_flag, mem_wr}, 32'd2);
    LSB_req = 0; LSB_wr = 0;
    tick();

    // Outside the IO region a full buffer does not stall.
    io_buffer_full = 1;
    LSB_req = 1; LSB_wr = 1; LSB_size = SZ_B; LSB_addr = 32'h0002_0000; LSB_wdata = 32'h0000_003C;
    tick();
    check("nonio_no_stall", {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, 8'h3C});
    wait_lsb(10, seen);
    check("nonio_flag", {31'd0, seen}, 32'd1);
    LSB_req = 0; LSB_wr = 0; io_buffer_full = 0;
    tick();

    // rdy=0 pulse in the middle of a word store.
    base = wr_cnt;
    LSB_req = 1; LSB_wr = 1; LSB_size = SZ_W; LSB_addr = 32'h600; LSB_wdata = 32'h89AB_CDEF;
    tick(); tick();
    rdy = 0;
    #1;
    check("rdy_masks_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    check("rdy_frozen_addr", mem_a, 32'h601);
    rdy = 1;
    wait_lsb(20, seen);
    check("rdy_wr_flag", {31'd0, seen}, 32'd1);
    LSB_req = 0; LSB_wr = 0;
    tick();
    check("rdy_wr_count", wr_cnt - base, 32'd4);
    check("rdy_wr_ram", ram_word(32'h600), 32'h89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
